// File: rtl/fpdiv_seq.sv
// fpdiv_seq: sequential divider for the 13-bit float format
// {sign[12], exp[11:8] biased by BIAS, mantissa[7:0] U(8.7)}.
// A radix-2 restoring divider produces one quotient bit per cycle.
// Special operands (NaN, zero, inf, zero mantissa) bypass the iteration.
// Optional macro FPDIV_FLAGS_EN adds the o_flags status output.
module fpdiv_seq #(
    parameter int BIAS  = 7,
    parameter int QBITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [12:0] i_data1,
    input  logic [12:0] i_data2,
    output logic        o_busy,
    output logic        o_valid,
    output logic [12:0] o_div
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [3:0]  o_flags
`endif
);

    localparam int CW = $clog2(QBITS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIV    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [12:0] NAN = 13'h1F80;

    logic [1:0]       state_q, state_d;
    logic [12:0]      a_q, a_d;
    logic [12:0]      b_q, b_d;
    logic [QBITS-1:0] dvd_q, dvd_d;
    logic [7:0]       rem_q, rem_d;
    logic [QBITS-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [12:0]      div_q, div_d;

    // {hit, result}: special-case result by priority, hit=0 when none applies
    function automatic logic [13:0] special(input logic [12:0] a, input logic [12:0] b);
        logic s, a_inf, b_inf, a_zero, b_zero;
        s      = a[12] ^ b[12];
        a_inf  = (a[11:0] == 12'hF00);
        b_inf  = (b[11:0] == 12'hF00);
        a_zero = (a[11:0] == 12'h700);
        b_zero = (b[11:0] == 12'h700);
        if (a == NAN || b == NAN)               return {1'b1, NAN};
        if (a_zero && b_zero)                   return {1'b1, NAN};
        if (a_inf && b_inf)                     return {1'b1, NAN};
        if (b_zero || (b[7:0] == 8'h00 && !b_inf)) return {1'b1, s, 12'hF00};
        if (a_inf)                              return {1'b1, s, 12'hF00};
        if (a_zero || a[7:0] == 8'h00 || b_inf) return {1'b1, s, 12'h700};
        return 14'h0000;
    endfunction

    // In IDLE classify the incoming operands, later the captured ones
    logic [12:0] cur_a, cur_b;
    logic [13:0] spec;
    assign cur_a = (state_q == IDLE) ? i_data1 : a_q;
    assign cur_b = (state_q == IDLE) ? i_data2 : b_q;
    assign spec  = special(cur_a, cur_b);

    // Normal-path result assembly from the finished quotient
    logic signed [5:0] e;
    logic [QBITS-1:0]  m_full;
    logic              sat;
    logic [7:0]        m8;
    logic [12:0]       norm;
    logic              s_out;
    always_comb begin
        s_out  = a_q[12] ^ b_q[12];
        e      = $signed({2'b00, a_q[11:8]}) - $signed({2'b00, b_q[11:8]}) + 6'(BIAS);
        m_full = (quo_q >> 1) + QBITS'(quo_q[0]);
        sat    = (m_full > QBITS'(255));
        m8     = sat ? 8'hFF : m_full[7:0];
        if (e < 6'sd0)
            norm = {s_out, 4'h7, 8'h00};
        else if (e >= 6'sd15)
            norm = {s_out, 4'hF, 8'h00};
        else
            norm = {s_out, e[3:0], m8};
    end

    // Divider step and FSM next-state
    logic [8:0] rem_sh;
    logic       ge;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        div_d   = div_q;
        rem_sh  = {rem_q, dvd_q[QBITS-1]};
        ge      = (rem_sh >= {1'b0, b_q[7:0]});
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d     = i_data1;
                    b_d     = i_data2;
                    dvd_d   = {i_data1[7:0], {(QBITS-8){1'b0}}};
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CW'(QBITS-1);
                    state_d = spec[13] ? FINISH : DIV;
                end
            end
            DIV: begin
                rem_d = ge ? 8'(rem_sh - {1'b0, b_q[7:0]}) : rem_sh[7:0];
                quo_d = {quo_q[QBITS-2:0], ge};
                dvd_d = {dvd_q[QBITS-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0)
                    state_d = FINISH;
            end
            FINISH: begin
                valid_d = 1'b1;
                div_d   = spec[13] ? spec[12:0] : norm;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            div_q   <= div_d;
        end
    end

`ifdef FPDIV_FLAGS_EN
    // Status flags captured alongside the result
    logic [3:0] flags_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            flags_q <= '0;
        else if (state_q == FINISH)
            flags_q <= {div_d == NAN,
                        div_d[11:0] == 12'hF00,
                        div_d[11:0] == 12'h700,
                        !spec[13] && sat && e >= 6'sd0 && e < 6'sd15};
    end
    assign o_flags = flags_q;
`endif

    assign o_busy  = (state_q != IDLE);
    assign o_valid = valid_q;
    assign o_div   = div_q;

endmodule

// File: doc/fpdiv_seq.md
Name: fpdiv_seq

Overview:
- Sequential floating-point divider for the team's 13-bit format: {sign[12], exp[11:8] biased by 7, mantissa[7:0] U(8.7) with an explicit leading bit}.
- Inverse operation of the combinational fpmul block; shares its encodings and special-value rules.
- Uses a start/valid handshake and a radix-2 restoring mantissa divider, one quotient bit per cycle.
- Sits beside fpmul in the arithmetic datapath; result = i_data1 / i_data2.

Parameters:
- BIAS, 7, exponent bias.
- QBITS, 16, quotient bits produced by the iterative divider (one per DIV cycle).

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_data1  input  13  dividend, captured when i_start accepted
- i_data2  input  13  divisor, captured when i_start accepted
- o_busy  output  1  high in DIV and FINISH
- o_valid  output  1  one-cycle pulse, o_div valid
- o_div  output  13  result, held until next o_valid

Behaviour:
- Encodings:
  - NaN = 13'h1F80.
  - inf = exp 4'hF, mantissa 0, either sign.
  - zero = exp 4'h7, mantissa 0, either sign.
- Reset (async, i_rst_n=0): state=IDLE; o_busy=0, o_valid=0, o_div=13'h0000; internal registers cleared. Reset mid-operation aborts the operation; no o_valid is produced for it.
- IDLE:
  - i_start=1 captures both operands and clears the remainder.
  - Special case detected → go to FINISH.
  - Otherwise → go to DIV with counter=QBITS-1.
  - i_start=0 → stay in IDLE.
- DIV, QBITS cycles of restoring division on dividend {m1,8'h00} by m2:
  - Shift remainder left one bit and bring in the next dividend bit.
  - If remainder >= m2: subtract m2, quotient bit=1; else quotient bit=0.
  - counter==0 → go to FINISH.
  - i_start is ignored throughout.
- FINISH, one cycle: register o_div, pulse o_valid, return to IDLE.
  - Normal latency from start acceptance to o_valid = QBITS+1 cycles (17).
  - Special-case latency = 1 cycle.
- Arithmetic:
  - sign = s1 ^ s2.
  - Exponent is a 6-bit signed value: e = e1 - e2 + BIAS, range -8..22.
  - Mantissa: q = 16-bit quotient; m = (q>>1) + q[0] (round half up). If m > 255, m saturates to 8'hFF.
  - e < 0 → signed zero.
  - e >= 15 → signed inf.
  - Otherwise o_div = {sign, e[3:0], m}.
- Special cases, checked in this priority order:
  1. Either operand is NaN → NaN.
  2. zero/zero → NaN.
  3. inf/inf → NaN.
  4. Divisor is zero, or divisor mantissa is 0 and divisor is not inf → signed inf.
  5. Dividend is inf → signed inf.
  6. Dividend is zero, dividend mantissa is 0, or divisor is inf → signed zero.
- Zero/inf checks compare bits [11:0] only; sign is ignored.
- No back-pressure: o_valid is a pulse and the consumer must sample it. A new i_start may be accepted in the cycle after o_valid (IDLE).

Optional Feature:
- Macro: FPDIV_FLAGS_EN.
- Defined:
  - Adds port o_flags, output, 4 bits: {nan, inf, zero_or_underflow, mant_saturated}.
  - o_flags is registered with o_div, valid with o_valid, held until the next o_valid, reset to 4'h0.
  - zero_or_underflow is set for both a special-case zero and e<0.
  - inf is set for a special-case inf and for e>=15.
- Undefined: port absent, no flag logic; o_div behaviour is identical.

Test Plan:
- Reset, then 0x0780 / 0x0880 (1.0/2.0) → o_valid exactly 17 cycles after start, o_div=13'h0680, o_busy high for 17 cycles.
- 0x0780 / 0x07C0 (1.0/1.5) → o_div=13'h0755 (q=170, m=85); 0x07FF / 0x0701 → saturated 13'h07FF, mant_saturated flag=1 when FPDIV_FLAGS_EN is defined.
- 0x0E80 / 0x0080 → e=21 → 13'h0F00; 0x0080 / 0x0E80 → e=-7 → 13'h0700; 0x1880 / 0x0700 → 13'h1F00; each special case gives o_valid 1 cycle after start.
- 0x0700 / 0x0700 → 13'h1F80; 0x1F80 / 0x0780 → 13'h1F80; 0x0F00 / 0x1F00 → 13'h1F80.
- Start 0x0780/0x0880, pulse i_start with 0x0880/0x0780 during cycle 5 of DIV → ignored, result 13'h0680, single o_valid; back-to-back start on the cycle after o_valid is accepted.
- Assert i_rst_n=0 asynchronously mid-DIV → o_busy, o_valid, o_div go to 0 immediately; after release, a new division completes correctly with no stale o_valid.
